fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter for the team's synchronous BRAM FIFO. It drains the FIFO through its `rd_en`/`empty`/`rd_data` port and presents the words as a valid/ready stream with `m_last` packet framing. It hides the BRAM's one-cycle registered read, including the stale word visible right after a write to an empty FIFO. A 2-entry output buffer absorbs downstream back-pressure.

## Interface
- `DATA_WIDTH`, 16, word width; must match the FIFO.
- `PACKET_LEN`, 8, words per packet; `m_last` marks the final word; legal range 1..2^CNT_WIDTH-1.
- `CNT_WIDTH`, 8, width of the packet counter and `word_count`.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  high permits new FIFO pops; low stops pops only.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO BRAM registered output.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop strobe to the FIFO; combinational.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_last`  out  1  last word of packet; qualified by `m_valid`.
- `m_ready`  in  1  downstream accept.
- `word_count`  out  CNT_WIDTH  total words accepted downstream; wraps modulo 2^CNT_WIDTH.

## Operation
- **`head_ok` register:** head word is settled on `fifo_rd_data`.
  - Next value: `head_ok <= ~fifo_empty & ~fifo_rd_en`.
  - It is always 0 in the cycle after a pop or after empty.
  - This guarantees the BRAM read address has been stable for one edge with a committed entry behind it.
- **Pop rule:** `fifo_rd_en = enable & head_ok & ~fifo_empty & (buf_count < 2)`.
- **Capture on pop:** at the pop edge, `fifo_rd_data` and `last_flag = (pkt_cnt == PACKET_LEN-1)` are written into the output buffer tail.
- **Packet counter `pkt_cnt`:**
  - Increments on each pop.
  - Wraps to 0 after PACKET_LEN-1.
  - Holds while `enable` is low; a packet may therefore span a disable.
- **Output buffer:** 2-entry circular buffer with head index, tail index and `buf_count` (0..2).
  - `m_valid = (buf_count != 0)`.
  - `m_data` and `m_last` come from the head entry.
- **Transfer:** `m_valid & m_ready` pops the buffer head and increments `word_count`.
  - A simultaneous pop and transfer leaves `buf_count` unchanged.
- **Controller states:**
  - IDLE: `enable` low or `fifo_empty` high.
  - SETTLE: `head_ok` = 0 with FIFO non-empty.
  - POP: `fifo_rd_en` high.
  - STALL: `head_ok` = 1 but buffer full.
- **Transitions:**
  - IDLE→SETTLE when `fifo_empty` falls with `enable` high.
  - SETTLE→POP next cycle.
  - POP→SETTLE if the FIFO is still non-empty, else POP→IDLE.
  - STALL→POP when `buf_count` drops below 2.
- **`enable` falling:** no further pops from that cycle on; buffered words still drain normally.
- **Reset values:** `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `word_count`=0, `pkt_cnt`=0, `head_ok`=0, `buf_count`=0.
- **Reset mid-packet:** buffered words are discarded, and the next popped word starts a new packet. The FIFO itself is reset by the same system reset.

## Timing
- **Write into empty FIFO:** write at edge E0 → `fifo_empty` low in cycle 1 → `head_ok` high in cycle 2, `fifo_rd_en` high in cycle 2 → `m_valid` high in cycle 3.
  - Latency from write to `m_valid`: 3 cycles.
- **Peak throughput:** one pop every 2 cycles; `m_valid` stays high only while downstream drains no faster than that.
- **Back-pressure:** with `m_ready` low, at most 2 words are popped; then `fifo_rd_en` stays 0.
- **`m_ready` rising after a stall:** a transfer occurs that cycle. The next pop can issue in the same cycle only if `buf_count` was already below 2.
- **`m_data`/`m_last` stability:** both stay stable while `m_valid & ~m_ready`.
- **Async reset:** assertion clears outputs without waiting for a clock edge. Release is synchronized externally; the first pop is possible 2 cycles after release if the FIFO is non-empty.

## Test plan
- Reset, then a single word 0xA5A5 written into an empty FIFO with `m_ready`=1 → `m_valid` exactly 3 cycles after the write edge, `m_data`=0xA5A5, `word_count`=1, no spurious early word.
- 16 words 0..15 preloaded, `PACKET_LEN`=8, `m_ready`=1 → data 0..15 in order, one beat every 2 cycles, `m_last` high on words 7 and 15 only, `word_count`=16.
- 10 words preloaded, `m_ready` held low 20 cycles → exactly 2 pops and `fifo_rd_en` silent thereafter. Then `m_ready`=1 → all 10 words delivered in order with no loss or duplication.
- `enable` dropped after word 3 of a packet, raised 10 cycles later → at most the 2 buffered words emerge while disabled, then words resume. `m_last` lands on the 8th word overall.
- Async reset pulse mid-stream with 2 words buffered → `m_valid`, `fifo_rd_en` and `word_count` go 0 before the next edge. After release and refill, the first `m_last` comes on the 8th word.
- `CNT_WIDTH`=4, 20 words streamed → `word_count` wraps to 4. With `PACKET_LEN`=1, `m_last` is high on every word.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous BRAM FIFO: pops words once the registered read
// data has settled and presents them as a valid/ready stream with packet framing.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PACKET_LEN = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_POP, ST_STALL} state_e;

  state_e                state;
  logic                  head_ok_q, head_ok_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic                  wr_idx_q, rd_idx_q;
  logic [DATA_WIDTH:0]   buf_q [2];
  logic [DATA_WIDTH:0]   head_w;
  logic                  pop, xfer, last_flag;

  // head_ok is the only controller memory; the phase is decoded from it each cycle
  // because the pop must react combinationally to enable and fifo_empty.
  always_comb begin
    state = ST_IDLE;
    if (enable && !fifo_empty) begin
      if (!head_ok_q)              state = ST_SETTLE;
      else if (buf_count_q == 2'd2) state = ST_STALL;
      else                         state = ST_POP;
    end
  end

  assign fifo_rd_en = (state == ST_POP);
  assign pop        = fifo_rd_en;
  assign head_w     = buf_q[rd_idx_q];
  assign m_valid    = (buf_count_q != 2'd0);
  assign m_data     = head_w[DATA_WIDTH-1:0];
  assign m_last     = m_valid & head_w[DATA_WIDTH];
  assign xfer       = m_valid & m_ready;
  assign last_flag  = (pkt_cnt_q == CNT_WIDTH'(PACKET_LEN - 1));
  assign word_count = word_count_q;

  always_comb begin
    // A pop leaves the read address moving, so the next word needs one settle edge.
    head_ok_d    = ~fifo_empty & ~fifo_rd_en;
    pkt_cnt_d    = pkt_cnt_q;
    buf_count_d  = buf_count_q;
    word_count_d = word_count_q;
    if (pop) pkt_cnt_d = last_flag ? '0 : pkt_cnt_q + CNT_WIDTH'(1);
    if (xfer) word_count_d = word_count_q + CNT_WIDTH'(1);
    case ({pop, xfer})
      2'b10:   buf_count_d = buf_count_q + 2'd1;
      2'b01:   buf_count_d = buf_count_q - 2'd1;
      default: buf_count_d = buf_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ok_q    <= 1'b0;
      pkt_cnt_q    <= '0;
      word_count_q <= '0;
      buf_count_q  <= 2'd0;
      wr_idx_q     <= 1'b0;
      rd_idx_q     <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
    end else begin
      head_ok_q    <= head_ok_d;
      pkt_cnt_q    <= pkt_cnt_d;
      word_count_q <= word_count_d;
      buf_count_q  <= buf_count_d;
      if (pop) begin
        buf_q[wr_idx_q] <= {last_flag, fifo_rd_data};
        wr_idx_q        <= ~wr_idx_q;
      end
      if (xfer) rd_idx_q <= ~rd_idx_q;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: BRAM FIFO model feeding two DUT configurations, with
// observed stream beats compared against expected word/framing sequences.
module tb_fifo_stream_reader;
  localparam int DW = 16, PL = 8, CW = 8, PL2 = 1, CW2 = 4;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0, m_ready = 1'b0, wr_en = 1'b0;
  logic [DW-1:0] wr_dat = '0;
  logic          fifo_rd_en, fifo_empty, m_valid, m_last;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic [CW-1:0] word_count;

  logic           en2 = 1'b0, rdy2 = 1'b0, wr2 = 1'b0;
  logic [DW-1:0]  wd2 = '0;
  logic           rd2, emp2, mv2, ml2;
  logic [DW-1:0]  rdd2, md2;
  logic [CW2-1:0] wc2;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PACKET_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .word_count(word_count));

  fifo_stream_reader #(.DATA_WIDTH(DW), .PACKET_LEN(PL2), .CNT_WIDTH(CW2)) dut2 (
    .clk(clk), .reset(reset), .enable(en2), .fifo_rd_data(rdd2),
    .fifo_empty(emp2), .fifo_rd_en(rd2), .m_data(md2), .m_valid(mv2),
    .m_last(ml2), .m_ready(rdy2), .word_count(wc2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM FIFO models: registered read of the current address, read-before-write.
  logic [DW-1:0] mem1 [32];
  int wp1, rp1, cnt1;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp1 <= 0; rp1 <= 0; cnt1 <= 0; fifo_rd_data <= '0;
    end else begin
      fifo_rd_data <= mem1[rp1 % 32];
      if (wr_en) begin mem1[wp1 % 32] <= wr_dat; wp1 <= wp1 + 1; end
      if (fifo_rd_en) rp1 <= rp1 + 1;
      cnt1 <= cnt1 + (wr_en ? 1 : 0) - (fifo_rd_en ? 1 : 0);
    end
  end
  assign fifo_empty = (cnt1 == 0);

  logic [DW-1:0] mem2 [32];
  int wp2, rp2, cnt2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp2 <= 0; rp2 <= 0; cnt2 <= 0; rdd2 <= '0;
    end else begin
      rdd2 <= mem2[rp2 % 32];
      if (wr2) begin mem2[wp2 % 32] <= wd2; wp2 <= wp2 + 1; end
      if (rd2) rp2 <= rp2 + 1;
      cnt2 <= cnt2 + (wr2 ? 1 : 0) - (rd2 ? 1 : 0);
    end
  end
  assign emp2 = (cnt2 == 0);

  // Recorders: every accepted beat and every pop strobe, sampled mid-cycle.
  logic [DW-1:0] obs_d[$], obs2_d[$];
  logic          obs_l[$], obs2_l[$];
  int            obs_c[$];
  int            pops = 0;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      obs_d.push_back(m_data); obs_l.push_back(m_last); obs_c.push_back(cyc);
    end
    if (mv2 && rdy2) begin obs2_d.push_back(md2); obs2_l.push_back(ml2); end
    if (fifo_rd_en) pops <= pops + 1;
  end

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wr1(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_dat = d; tick(); wr_en = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", m_valid); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b expected 0", m_last); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h expected 0", m_data); end
    n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL rst_wcount: got %0d expected 0", word_count); end
    n_cmp++; if (wc2 !== '0) begin n_bad++; $display("FAIL rst_wcount2: got %0d expected 0", wc2); end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_single();
    int b, w;
    do_reset(); enable = 1'b1; m_ready = 1'b1;
    b = obs_d.size(); w = cyc;
    wr1(16'hA5A5);
    repeat (10) tick();
    n_cmp++; if (obs_d.size() - b !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", obs_d.size() - b); end
    if (obs_d.size() > b) begin
      n_cmp++; if (obs_c[b] !== w + 3) begin n_bad++; $display("FAIL single_latency: got cycle %0d expected %0d", obs_c[b], w + 3); end
      n_cmp++; if (obs_d[b] !== 16'hA5A5) begin n_bad++; $display("FAIL single_data: got %h expected a5a5", obs_d[b]); end
      n_cmp++; if (obs_l[b] !== 1'b0) begin n_bad++; $display("FAIL single_last: got %b expected 0", obs_l[b]); end
    end
    n_cmp++; if (word_count !== CW'(1)) begin n_bad++; $display("FAIL single_wcount: got %0d expected 1", word_count); end
  endtask

  task automatic test_stream();
    int b;
    do_reset(); enable = 1'b0; m_ready = 1'b1; exp_q.delete();
    for (int i = 0; i < 16; i++) begin wr1(DW'(i)); exp_q.push_back(DW'(i)); end
    b = obs_d.size(); enable = 1'b1;
    repeat (45) tick();
    n_cmp++; if (obs_d.size() - b !== 16) begin n_bad++; $display("FAIL stream_count: got %0d expected 16", obs_d.size() - b); end
    for (int i = 0; i < 16; i++) if (b + i < obs_d.size()) begin
      n_cmp++; if (obs_d[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL stream_data[%0d]: got %h expected %h", i, obs_d[b+i], exp_q[i]); end
      n_cmp++; if (obs_l[b+i] !== (i % PL == PL - 1)) begin n_bad++; $display("FAIL stream_last[%0d]: got %b expected %b", i, obs_l[b+i], (i % PL == PL - 1)); end
      if (i > 0) begin
        n_cmp++; if (obs_c[b+i] - obs_c[b+i-1] !== 2) begin n_bad++; $display("FAIL stream_gap[%0d]: got %0d expected 2", i, obs_c[b+i] - obs_c[b+i-1]); end
      end
    end
    n_cmp++; if (word_count !== CW'(16)) begin n_bad++; $display("FAIL stream_wcount: got %0d expected 16", word_count); end
  endtask

  task automatic test_backpressure();
    int b, p0;
    do_reset(); enable = 1'b1; m_ready = 1'b0; exp_q.delete();
    b = obs_d.size(); p0 = pops;
    for (int i = 0; i < 10; i++) begin exp_q.push_back(DW'($urandom)); wr1(exp_q[i]); end
    repeat (20) tick();
    n_cmp++; if (pops - p0 !== 2) begin n_bad++; $display("FAIL bp_pops: got %0d expected 2", pops - p0); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en); end
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
    n_cmp++; if (m_data !== exp_q[0]) begin n_bad++; $display("FAIL bp_hold_data: got %h expected %h", m_data, exp_q[0]); end
    m_ready = 1'b1;
    repeat (40) tick();
    n_cmp++; if (obs_d.size() - b !== 10) begin n_bad++; $display("FAIL bp_count: got %0d expected 10", obs_d.size() - b); end
    for (int i = 0; i < 10; i++) if (b + i < obs_d.size()) begin
      n_cmp++; if (obs_d[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_data[%0d]: got %h expected %h", i, obs_d[b+i], exp_q[i]); end
      n_cmp++; if (obs_l[b+i] !== (i % PL == PL - 1)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b expected %b", i, obs_l[b+i], (i % PL == PL - 1)); end
    end
    n_cmp++; if (word_count !== CW'(10)) begin n_bad++; $display("FAIL bp_wcount: got %0d expected 10", word_count); end
  endtask

  task automatic test_enable();
    int b, p0;
    do_reset(); enable = 1'b0; m_ready = 1'b1; exp_q.delete();
    for (int i = 0; i < 12; i++) begin exp_q.push_back(DW'($urandom)); wr1(exp_q[i]); end
    b = obs_d.size(); p0 = pops; enable = 1'b1;
    for (int i = 0; i < 40 && pops - p0 < 3; i++) tick();
    enable = 1'b0;
    n_cmp++; if (pops - p0 !== 3) begin n_bad++; $display("FAIL en_reach3: got %0d pops expected 3", pops - p0); end
    repeat (10) tick();
    n_cmp++; if (pops - p0 !== 3) begin n_bad++; $display("FAIL en_no_pop: got %0d pops expected 3", pops - p0); end
    n_cmp++; if (obs_d.size() - b !== 3) begin n_bad++; $display("FAIL en_drained: got %0d expected 3", obs_d.size() - b); end
    enable = 1'b1;
    repeat (60) begin m_ready = 1'($urandom_range(0, 1)); tick(); end
    m_ready = 1'b1;
    repeat (30) tick();
    n_cmp++; if (obs_d.size() - b !== 12) begin n_bad++; $display("FAIL en_count: got %0d expected 12", obs_d.size() - b); end
    for (int i = 0; i < 12; i++) if (b + i < obs_d.size()) begin
      n_cmp++; if (obs_d[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL en_data[%0d]: got %h expected %h", i, obs_d[b+i], exp_q[i]); end
      n_cmp++; if (obs_l[b+i] !== (i % PL == PL - 1)) begin n_bad++; $display("FAIL en_last[%0d]: got %b expected %b", i, obs_l[b+i], (i % PL == PL - 1)); end
    end
    n_cmp++; if (word_count !== CW'(12)) begin n_bad++; $display("FAIL en_wcount: got %0d expected 12", word_count); end
  endtask

  task automatic test_async_reset();
    int b, p0;
    do_reset(); enable = 1'b1; m_ready = 1'b1; exp_q.delete();
    b = obs_d.size(); p0 = pops;
    for (int i = 0; i < 6; i++) wr1(DW'($urandom));
    for (int i = 0; i < 40 && obs_d.size() - b < 2; i++) tick();
    m_ready = 1'b0;
    repeat (12) tick();
    n_cmp++; if ((pops - p0) - (obs_d.size() - b) !== 2) begin n_bad++; $display("FAIL ar_buffered: got %0d expected 2", (pops - p0) - (obs_d.size() - b)); end
    @(posedge clk); #2; reset = 1'b1; #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b expected 0", m_valid); end
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL ar_rd_en: got %b expected 0", fifo_rd_en); end
    n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL ar_wcount: got %0d expected 0", word_count); end
    tick(); reset = 1'b0; m_ready = 1'b1; tick();
    b = obs_d.size();
    for (int i = 0; i < 10; i++) begin exp_q.push_back(DW'($urandom)); wr1(exp_q[i]); end
    repeat (40) tick();
    n_cmp++; if (obs_d.size() - b !== 10) begin n_bad++; $display("FAIL ar_count: got %0d expected 10", obs_d.size() - b); end
    for (int i = 0; i < 10; i++) if (b + i < obs_d.size()) begin
      n_cmp++; if (obs_d[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL ar_data[%0d]: got %h expected %h", i, obs_d[b+i], exp_q[i]); end
      n_cmp++; if (obs_l[b+i] !== (i % PL == PL - 1)) begin n_bad++; $display("FAIL ar_last[%0d]: got %b expected %b", i, obs_l[b+i], (i % PL == PL - 1)); end
    end
  endtask

  task automatic test_wrap();
    int b;
    do_reset(); en2 = 1'b1; rdy2 = 1'b1; exp_q.delete();
    b = obs2_d.size();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(DW'($urandom)); wr2 = 1'b1; wd2 = exp_q[i]; tick(); wr2 = 1'b0;
    end
    repeat (50) tick();
    n_cmp++; if (obs2_d.size() - b !== 20) begin n_bad++; $display("FAIL wrap_count: got %0d expected 20", obs2_d.size() - b); end
    for (int i = 0; i < 20; i++) if (b + i < obs2_d.size()) begin
      n_cmp++; if (obs2_d[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, obs2_d[b+i], exp_q[i]); end
      n_cmp++; if (obs2_l[b+i] !== 1'b1) begin n_bad++; $display("FAIL wrap_last[%0d]: got %b expected 1", i, obs2_l[b+i]); end
    end
    n_cmp++; if (wc2 !== CW2'(20 % 16)) begin n_bad++; $display("FAIL wrap_wcount: got %0d expected 4", wc2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
